// File: rtl/gt_rx_link_ctrl.sv
// GT RX lane bring-up and supervision: reset pulse, resetdone wait, comma realign, blind period,
// IDLE-qualified lock, then monitoring of alignment, elastic buffer and IDLE cadence while up.
module gt_rx_link_ctrl #(
    parameter logic [15:0] g_IDLE          = 16'hbc95,
    parameter int          g_IDLE_PERIOD   = 193,
    parameter int          g_RESET_CYCLES  = 16,
    parameter int          g_BLIND_PERIOD  = 10,
    parameter int          g_NUM_IDLE_LOCK = 4,
    parameter int          g_TIMEOUT       = 65535
) (
    input  logic        usrclk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        rx_resetdone_i,
    input  logic        rx_aligned_i,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_k_i,
    input  logic [2:0]  rx_bufstatus_i,
    output logic        gt_rxreset_o,
    output logic        rx_realign_o,
    output logic        link_up_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_cnt_o,
    output logic [15:0] buf_err_cnt_o
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_REALIGN   = 3'd3,
        S_BLIND     = 3'd4,
        S_LOCK      = 3'd5,
        S_UP        = 3'd6
    } state_t;

    // Terminal values of the shared cycle counter for each timed condition.
    localparam logic [15:0] RESET_LAST   = 16'(g_RESET_CYCLES - 1);
    localparam logic [15:0] BLIND_LAST   = 16'(g_BLIND_PERIOD - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(g_TIMEOUT - 1);
    localparam logic [15:0] WDOG_LAST    = 16'(2 * g_IDLE_PERIOD - 1);
    localparam logic [15:0] IDLE_LAST    = 16'(g_NUM_IDLE_LOCK - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] idle_cnt_q;
    logic [7:0]  retry_q;
    logic [15:0] buf_err_q;
    logic        rxreset_q;
    logic        realign_q;
    logic        link_up_q;

    logic        is_idle;
    logic        bad_k;
    logic        retry_inc;
    logic        buf_err_inc;
    logic        idle_inc;
    logic        wdog_clr;
    logic        unused_bufstatus;

    assign is_idle = (rx_k_i == 2'b10) && (rx_data_i == g_IDLE);
    // Data words carry no K flag; any K pattern other than a correct IDLE means misalignment.
    assign bad_k   = (rx_k_i != 2'b00) && !is_idle;

    // Only the under/overflow flag of the elastic buffer status is of interest.
    assign unused_bufstatus = ^rx_bufstatus_i[1:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = state_q;
        retry_inc   = 1'b0;
        buf_err_inc = 1'b0;
        idle_inc    = 1'b0;
        wdog_clr    = 1'b0;
        if (!enable_i) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: state_d = S_RESET;
                S_RESET: begin
                    if (cnt_q == RESET_LAST) state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (rx_resetdone_i) begin
                        state_d = S_REALIGN;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d   = S_RESET;
                        retry_inc = 1'b1;
                    end
                end
                S_REALIGN: begin
                    if (rx_aligned_i) begin
                        state_d = S_BLIND;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d   = S_RESET;
                        retry_inc = 1'b1;
                    end
                end
                S_BLIND: begin
                    if (!rx_aligned_i) state_d = S_REALIGN;
                    else if (cnt_q == BLIND_LAST) state_d = S_LOCK;
                end
                S_LOCK: begin
                    if (!rx_aligned_i || bad_k) begin
                        state_d = S_REALIGN;
                    end else if (is_idle && idle_cnt_q == IDLE_LAST) begin
                        state_d = S_UP;
                    end else begin
                        idle_inc = is_idle;
                        if (cnt_q == TIMEOUT_LAST) begin
                            state_d   = S_RESET;
                            retry_inc = 1'b1;
                        end
                    end
                end
                S_UP: begin
                    if (rx_bufstatus_i[2]) begin
                        state_d     = S_RESET;
                        buf_err_inc = 1'b1;
                    end else if (!rx_aligned_i || bad_k) begin
                        state_d = S_REALIGN;
                    end else if (is_idle) begin
                        wdog_clr = 1'b1;
                    end else if (cnt_q == WDOG_LAST) begin
                        state_d = S_REALIGN;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            retry_q    <= '0;
            buf_err_q  <= '0;
            rxreset_q  <= 1'b0;
            realign_q  <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            if (state_d != state_q || wdog_clr) cnt_q <= '0;
            else if (cnt_q != 16'hffff)          cnt_q <= cnt_q + 16'd1;

            if (state_d != state_q) idle_cnt_q <= '0;
            else if (idle_inc)      idle_cnt_q <= idle_cnt_q + 16'd1;

            if (retry_inc && retry_q != 8'hff)       retry_q   <= retry_q + 8'd1;
            if (buf_err_inc && buf_err_q != 16'hffff) buf_err_q <= buf_err_q + 16'd1;

            // Outputs decode the next state so they change on the same edge as state_o.
            rxreset_q <= (state_d == S_RESET);
            realign_q <= (state_d == S_REALIGN);
            link_up_q <= (state_d == S_UP);
        end
    end

    assign gt_rxreset_o  = rxreset_q;
    assign rx_realign_o  = realign_q;
    assign link_up_o     = link_up_q;
    assign state_o       = state_q;
    assign retry_cnt_o   = retry_q;
    assign buf_err_cnt_o = buf_err_q;

endmodule

// File: tb/tb_gt_rx_link_ctrl.sv
// Bench for gt_rx_link_ctrl: lane 0 (default timeout) runs the bring-up/error scenarios, lane 1
// (timeout 100) runs the retry scenario; a reference model checks both lanes every cycle.
module tb_gt_rx_link_ctrl;

    localparam logic [15:0] P_IDLE   = 16'hbc95;
    localparam int          P_PERIOD = 193;
    localparam int          P_RESET  = 16;
    localparam int          P_BLIND  = 10;
    localparam int          P_NLOCK  = 4;

    localparam int OFF = 0, RESET = 1, WAIT = 2, REALIGN = 3, BLIND = 4, LOCK = 5, UP = 6;

    typedef struct {
        int phase;
        int t;
        int idles;
        int retries;
        int buf_errs;
    } lane_model_t;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  enable;
    logic [1:0]  resetdone;
    logic [1:0]  aligned;
    logic [15:0] data [2];
    logic [1:0]  k [2];
    logic [2:0]  bufst [2];
    logic [1:0]  rxreset;
    logic [1:0]  realign;
    logic [1:0]  link_up;
    logic [2:0]  st [2];
    logic [7:0]  retry [2];
    logic [15:0] buf_err [2];

    int n_cmp = 0;
    int n_fail = 0;
    int word_idx = 0;
    bit lane1_done = 1'b0;
    lane_model_t m [2];
    int timeout_of [2] = '{65535, 100};

    always #5 clk = ~clk;

    gt_rx_link_ctrl dut0 (
        .usrclk_i(clk), .rst_n_i(rst_n[0]), .enable_i(enable[0]),
        .rx_resetdone_i(resetdone[0]), .rx_aligned_i(aligned[0]),
        .rx_data_i(data[0]), .rx_k_i(k[0]), .rx_bufstatus_i(bufst[0]),
        .gt_rxreset_o(rxreset[0]), .rx_realign_o(realign[0]), .link_up_o(link_up[0]),
        .state_o(st[0]), .retry_cnt_o(retry[0]), .buf_err_cnt_o(buf_err[0])
    );

    gt_rx_link_ctrl #(.g_TIMEOUT(100)) dut1 (
        .usrclk_i(clk), .rst_n_i(rst_n[1]), .enable_i(enable[1]),
        .rx_resetdone_i(resetdone[1]), .rx_aligned_i(aligned[1]),
        .rx_data_i(data[1]), .rx_k_i(k[1]), .rx_bufstatus_i(bufst[1]),
        .gt_rxreset_o(rxreset[1]), .rx_realign_o(realign[1]), .link_up_o(link_up[1]),
        .state_o(st[1]), .retry_cnt_o(retry[1]), .buf_err_cnt_o(buf_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Lane 0 word stream: an IDLE every P_PERIOD words, plain data words otherwise.
    task automatic drive_word();
        if (word_idx % P_PERIOD == 0) begin
            data[0] = P_IDLE;
            k[0]    = 2'b10;
        end else begin
            data[0] = 16'(word_idx * 7 + 3);
            k[0]    = 2'b00;
        end
        word_idx++;
    endtask

    task automatic run_until(input int target, input int bound, input string name);
        int n = 0;
        while (st[0] != 3'(target) && n < bound) begin
            drive_word();
            tick();
            n++;
        end
        check(name, 32'(st[0]), 32'(target));
    endtask

    // Behavioural model: time spent in the current phase drives every timed rule.
    function automatic lane_model_t model_step(lane_model_t cur, logic en, logic done, logic al,
                                               logic [15:0] d, logic [1:0] kf, logic [2:0] bs,
                                               int timeout);
        lane_model_t nx = cur;
        int  goto_phase = cur.phase;
        int  elapsed    = cur.t + 1;
        bit  idle       = (kf == 2'b10) && (d == P_IDLE);
        bit  bad        = (kf != 2'b00) && !idle;
        bit  retry_now  = 1'b0;
        nx.t = elapsed;
        if (!en) goto_phase = OFF;
        else if (cur.phase == OFF) goto_phase = RESET;
        else if (cur.phase == RESET) begin
            if (elapsed >= P_RESET) goto_phase = WAIT;
        end else if (cur.phase == WAIT) begin
            if (done) goto_phase = REALIGN;
            else if (elapsed >= timeout) retry_now = 1'b1;
        end else if (cur.phase == REALIGN) begin
            if (al) goto_phase = BLIND;
            else if (elapsed >= timeout) retry_now = 1'b1;
        end else if (cur.phase == BLIND) begin
            if (!al) goto_phase = REALIGN;
            else if (elapsed >= P_BLIND) goto_phase = LOCK;
        end else if (cur.phase == LOCK) begin
            if (!al || bad) goto_phase = REALIGN;
            else begin
                if (idle) nx.idles = cur.idles + 1;
                if (nx.idles >= P_NLOCK) goto_phase = UP;
                else if (elapsed >= timeout) retry_now = 1'b1;
            end
        end else if (cur.phase == UP) begin
            if (bs[2]) begin
                goto_phase = RESET;
                if (nx.buf_errs < 65535) nx.buf_errs++;
            end else if (!al || bad) goto_phase = REALIGN;
            else if (idle) nx.t = 0;
            else if (elapsed >= 2 * P_PERIOD) goto_phase = REALIGN;
        end
        if (retry_now) begin
            goto_phase = RESET;
            if (nx.retries < 255) nx.retries++;
        end
        if (goto_phase != cur.phase) begin
            nx.t     = 0;
            nx.idles = 0;
        end
        nx.phase = goto_phase;
        return nx;
    endfunction

    initial begin
        for (int l = 0; l < 2; l++) m[l] = '{default: 0};
        forever begin
            @(posedge clk);
            for (int l = 0; l < 2; l++) begin
                if (!rst_n[l]) m[l] = '{default: 0};
                else m[l] = model_step(m[l], enable[l], resetdone[l], aligned[l], data[l], k[l],
                                       bufst[l], timeout_of[l]);
            end
            #1;
            for (int l = 0; l < 2; l++) begin
                check($sformatf("lane%0d_outputs", l),
                      {2'b0, st[l], rxreset[l], realign[l], link_up[l], retry[l], buf_err[l]},
                      {2'b0, 3'(m[l].phase), m[l].phase == RESET, m[l].phase == REALIGN,
                       m[l].phase == UP, 8'(m[l].retries), 16'(m[l].buf_errs)});
            end
        end
    end

    // Lane 1: resetdone never arrives, so every attempt times out after RESET + WAIT_DONE.
    initial begin
        int n;
        rst_n[1] = 1'b0; enable[1] = 1'b0; resetdone[1] = 1'b0; aligned[1] = 1'b0;
        data[1] = '0; k[1] = '0; bufst[1] = '0;
        repeat (3) tick();
        rst_n[1] = 1'b1; enable[1] = 1'b1;
        tick();
        check("l1_first_reset", 32'(st[1]), 1);
        for (int i = 1; i <= 3; i++) begin
            n = 0;
            while (st[1] != 3'd2 && n < 500) begin tick(); n++; end
            while (st[1] != 3'd1 && n < 500) begin tick(); n++; end
            check($sformatf("l1_retry_period_%0d", i), 32'(n), 116);
            check($sformatf("l1_retry_cnt_%0d", i), 32'(retry[1]), 32'(i));
        end
        repeat (300 * 116) tick();
        check("l1_retry_saturated", 32'(retry[1]), 255);
        lane1_done = 1'b1;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n[0] = 1'b0; enable[0] = 1'b0; resetdone[0] = 1'b0; aligned[0] = 1'b0;
        data[0] = '0; k[0] = '0; bufst[0] = '0;
        repeat (3) tick();
        check("rst_state", 32'(st[0]), 0);
        check("rst_rxreset", 32'(rxreset[0]), 0);
        check("rst_link_up", 32'(link_up[0]), 0);
        check("rst_counters", {8'(retry[0]), 16'(buf_err[0])}, 0);

        // Scenario 1: clean bring-up.
        rst_n[0] = 1'b1; enable[0] = 1'b1;
        n = 0;
        tick();
        while (rxreset[0] && n < 100) begin n++; tick(); end
        check("t1_rxreset_cycles", 32'(n), 16);
        check("t1_wait_done", 32'(st[0]), 2);
        repeat (5) tick();
        resetdone[0] = 1'b1;
        tick();
        check("t1_realign_state", 32'(st[0]), 3);
        check("t1_realign_out", 32'(realign[0]), 1);
        repeat (2) tick();
        aligned[0] = 1'b1;
        tick();
        n = 0;
        while (st[0] == 3'd4 && n < 100) begin n++; tick(); end
        check("t1_blind_cycles", 32'(n), 10);
        check("t1_lock", 32'(st[0]), 5);
        word_idx = 0;
        for (int i = 0; i < 580; i++) begin
            drive_word();
            tick();
            if (i == 386) check("t1_no_link_after_3rd_idle", {31'd0, link_up[0]}, 0);
        end
        check("t1_link_up", {31'd0, link_up[0]}, 1);
        check("t1_up_state", 32'(st[0]), 6);
        check("t1_counters", {8'(retry[0]), 16'(buf_err[0])}, 0);

        // Scenario 3: byte-swapped comma while up.
        data[0] = 16'h95bc; k[0] = 2'b01;
        tick();
        check("t3_realign_state", 32'(st[0]), 3);
        check("t3_link_dropped", {31'd0, link_up[0]}, 0);
        check("t3_realign_out", {31'd0, realign[0]}, 1);
        word_idx = 1;
        run_until(UP, 3000, "t3_back_up");
        check("t3_retry_unchanged", 32'(retry[0]), 0);

        // Scenario 4: elastic buffer error while up.
        drive_word();
        bufst[0] = 3'b101;
        tick();
        bufst[0] = 3'b000;
        check("t4_buf_err_cnt", 32'(buf_err[0]), 1);
        check("t4_reset_state", 32'(st[0]), 1);
        check("t4_rxreset_out", {31'd0, rxreset[0]}, 1);
        run_until(UP, 3000, "t4_back_up");

        // Scenario 5: IDLE starvation trips the watchdog.
        word_idx = 0;
        drive_word();
        tick();
        n = 0;
        do begin
            data[0] = 16'h0055; k[0] = 2'b00;
            tick();
            n++;
        end while (st[0] == 3'd6 && n < 1000);
        check("t5_watchdog_cycles", 32'(n), 386);
        check("t5_realign_state", 32'(st[0]), 3);

        // Scenario 6: disable mid-LOCK, then asynchronous reset mid-UP.
        word_idx = 1;
        run_until(LOCK, 200, "t6_reach_lock");
        enable[0] = 1'b0;
        drive_word();
        tick();
        check("t6_off_state", 32'(st[0]), 0);
        check("t6_off_flags", {29'd0, rxreset[0], realign[0], link_up[0]}, 0);
        check("t6_counters_held", {8'(retry[0]), 16'(buf_err[0])}, 1);
        enable[0] = 1'b1;
        run_until(UP, 3000, "t6_reach_up");
        rst_n[0] = 1'b0;
        #1;
        check("t6_async_rst_state", 32'(st[0]), 0);
        check("t6_async_rst_flags", {29'd0, rxreset[0], realign[0], link_up[0]}, 0);
        check("t6_async_rst_counters", {8'(retry[0]), 16'(buf_err[0])}, 0);
        repeat (2) tick();
        rst_n[0] = 1'b1;
        tick();

        wait (lane1_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
